lin_gain_sat: RTL and testbench
===============================

// Module: lin_gain_sat
// PURPOSE
//  Multi-lane AXI4-Stream gain stage with rounding, offset and saturation.
//  Per lane: sto = sat_DWO(round((sti * cfg_mul) >>> SHIFT) + cfg_off).
//  Two-stage registered pipeline with full backpressure and per-lane sticky overflow flags.
//  Sits between the ADC/DAC data paths and the calibration/scope blocks; replaces the unclamped gain stage.
// PARAMETERS
//  DN     1   number of parallel lanes per beat
//  DWI    14  input sample width, signed
//  DWM    16  gain width, signed fixed-point, unity = 2**SHIFT
//  DWO    14  output sample width, signed
//  SHIFT  14  arithmetic right shift applied to the product, 1..DWI+DWM-2
//  ROUND  1   1: add 2**(SHIFT-1) before shift (round half up); 0: truncate (floor)
// PORTS
//  ACLK          in   1       clock
//  ARESETn       in   1       asynchronous reset, active low
//  sti_tdata     in   DN*DWI  input samples, lane i at [i*DWI+:DWI]
//  sti_tkeep     in   DN      lane valid
//  sti_tlast     in   1       end of packet
//  sti_tvalid    in   1       input valid
//  sti_tready    out  1       input ready
//  sto_tdata     out  DN*DWO  output samples
//  sto_tkeep     out  DN      lane valid, delayed with data
//  sto_tlast     out  1       end of packet, delayed with data
//  sto_tvalid    out  1       output valid
//  sto_tready    in   1       output ready
//  cfg_mul       in   DWM     gain, common to all lanes
//  cfg_off       in   DWO     signed offset added after shift
//  cfg_sat       in   1       1: clamp on overflow; 0: wrap (keep DWO LSBs)
//  ctl_clr       in   1       one-cycle pulse: clear sts_ovf and sts_cnt
//  sts_ovf       out  DN      sticky per-lane overflow flag
//  sts_cnt       out  32      count of output beats with >=1 overflowing kept lane, saturates at 2**32-1
// BEHAVIOUR
//  Reset (async assert, sync release): v1=v2=0, sto_tvalid=0, sts_ovf=0, sts_cnt=0; data/keep/last regs undefined.
//  Stage handshake: rdy2 = ~v2 | sto_tready; rdy1 = ~v1 | rdy2; sti_tready = rdy1 (combinational chain).
//  S1 (on sti_tvalid & rdy1): p[i] = sti[i]*cfg_mul, full DWI+DWM signed; keep/last captured; v1<=1.
//   If rdy1 & ~sti_tvalid: v1<=0.
//  S2 (on v1 & rdy2): r = (p + (ROUND ? 2**(SHIFT-1) : 0)) >>> SHIFT;
//   s = r + sext(cfg_off), computed at width max(DWI+DWM-SHIFT,DWO)+2 so no internal wrap;
//   ovf[i] = s outside [-2**(DWO-1), 2**(DWO-1)-1];
//   out = ovf ? (cfg_sat ? (s<0 ? min : max) : s[DWO-1:0]) : s[DWO-1:0]; v2<=1.
//   If rdy2 & ~v1: v2<=0.
//  Latency: 2 cycles sti transfer -> sto_tvalid with no backpressure; throughput 1 beat/cycle.
//  Stall: sto_tready=0 holds both stages; no beat lost or duplicated; sto_* stable while valid & ~ready.
//  Config sampling: cfg_mul at S1 load, cfg_off/cfg_sat at S2 load; changes mid-stream apply per beat at that point.
//  Status: on S2 load, sts_ovf[i] |= ovf[i] & keep[i]; sts_cnt += |(ovf & keep) (saturating).
//   ctl_clr with no S2-load event: flags/count -> 0.
//   ctl_clr coinciding with an overflow event: clear then apply (flag=new ovf, count=1).
//  Lanes with tkeep=0: data still computed and passed, never set flags or count.
//  Reset mid-packet: pipeline emptied, partial packet dropped, no tlast emitted for it.
// TESTING (DN=2, DWI=14, DWM=16, DWO=14, SHIFT=14, ROUND=1, cfg_off=0, cfg_sat=1 unless noted)
//  Unity: mul=16384, x={1000,-1000} -> sto={1000,-1000} exactly 2 cycles later, no flags.
//  Round: mul=8192, x=1 -> 1 (ROUND=1); rebuild ROUND=0 -> 0; x=-1 -> 0 (ROUND=1), -1 (ROUND=0).
//  Saturation: mul=32767, x={8191,-8192} -> {8191,-8192} clamped, sts_ovf=2'b11, sts_cnt=1; cfg_sat=0 -> wrapped LSBs.
//  Offset: mul=16384, x=8000, off=500 -> 8191 and ovf lane set; x=0, off=-100 -> -100, no flag.
//  Backpressure: 20-beat ramp, sto_tready random 50% plus 5-cycle hold low -> ramp out in order, no loss, tlast on beat 20.
//  Clear/reset: ctl_clr coincident with overflow beat -> ovf=1, cnt=1; ARESETn low mid-stream -> tvalid=0 immediately, status 0.

Source files
------------

// File: rtl/lin_gain_sat_if.sv
// ---------------------------------------------------------------------------
// lin_gain_sat_if
//   AXI4-Stream style bundle used on both sides of the gain stage.
//   Parameters:
//     DN  number of lanes per beat
//     DW  width of one lane sample
//   Signals:
//     tdata   DN*DW  lane i at [i*DW +: DW]
//     tkeep   DN     per-lane valid
//     tlast   1      end of packet
//     tvalid  1      beat valid (source)
//     tready  1      beat accepted (sink)
//   Modports:
//     master  drives tdata/tkeep/tlast/tvalid, receives tready
//     slave   receives tdata/tkeep/tlast/tvalid, drives tready
// ---------------------------------------------------------------------------
interface lin_gain_sat_if #(
   parameter int DN = 1,
   parameter int DW = 14
) ();
   logic [DN*DW-1:0] tdata;
   logic [DN-1:0]    tkeep;
   logic             tlast;
   logic             tvalid;
   logic             tready;

   modport master (
      output tdata, tkeep, tlast, tvalid,
      input  tready
   );

   modport slave (
      input  tdata, tkeep, tlast, tvalid,
      output tready
   );
endinterface

// File: rtl/lin_gain_sat.sv
// ---------------------------------------------------------------------------
// lin_gain_sat
//   Multi-lane gain stage: out = sat(round((in * cfg_mul) >>> SHIFT) + cfg_off)
//   Two registered stages with full backpressure, sticky per-lane overflow
//   flags and a saturating count of overflowing output beats.
//   Ports:
//     ACLK, ARESETn   clock, asynchronous active-low reset
//     sti             input stream  (slave,  DN lanes of DWI bits)
//     sto             output stream (master, DN lanes of DWO bits)
//     cfg_mul         signed gain, unity = 2**SHIFT, sampled at stage-1 load
//     cfg_off         signed offset, sampled at stage-2 load
//     cfg_sat         1: clamp on overflow, 0: keep DWO LSBs (wrap)
//     ctl_clr         single-cycle pulse clearing sts_ovf / sts_cnt
//     sts_ovf         sticky per-lane overflow flags (kept lanes only)
//     sts_cnt         beats with at least one overflowing kept lane
// ---------------------------------------------------------------------------
module lin_gain_sat #(
   parameter int DN    = 1,
   parameter int DWI   = 14,
   parameter int DWM   = 16,
   parameter int DWO   = 14,
   parameter int SHIFT = 14,
   parameter int ROUND = 1
) (
   input  logic             ACLK,
   input  logic             ARESETn,
   lin_gain_sat_if.slave    sti,
   lin_gain_sat_if.master   sto,
   input  logic [DWM-1:0]   cfg_mul,
   input  logic [DWO-1:0]   cfg_off,
   input  logic             cfg_sat,
   input  logic             ctl_clr,
   output logic [DN-1:0]    sts_ovf,
   output logic [31:0]      sts_cnt
);

   // Full product width, width of the shifted product, and the working
   // width of the offset sum (two guard bits so the add never wraps).
   localparam int PW = DWI + DWM;
   localparam int RW = PW - SHIFT;
   localparam int SW = ((RW > DWO) ? RW : DWO) + 2;

   // Rounding constant: half an LSB of the shifted result (round half up).
   localparam logic [PW:0] RND = (ROUND != 0) ? ((PW + 1)'(1) << (SHIFT - 1)) : '0;

   logic                   v1_reg;
   logic                   v2_reg;
   logic                   rdy1;
   logic                   rdy2;
   logic                   load1;
   logic                   load2;

   logic [DN-1:0][PW-1:0]  p1_reg;
   logic [DN-1:0][PW-1:0]  p_next;
   logic [DN-1:0]          keep1_reg;
   logic                   last1_reg;

   logic [DN*DWO-1:0]      data2_reg;
   logic [DN*DWO-1:0]      data_next;
   logic [DN-1:0]          keep2_reg;
   logic                   last2_reg;

   logic [DN-1:0]          ovf_next;
   logic [DN-1:0]          hit;

   // Ready ripples back combinationally so a full pipe still moves one
   // beat per cycle when the sink is ready.
   assign rdy2  = ~v2_reg | sto.tready;
   assign rdy1  = ~v1_reg | rdy2;
   assign load1 = sti.tvalid & rdy1;
   assign load2 = v1_reg & rdy2;

   assign sti.tready = rdy1;
   assign sto.tvalid = v2_reg;
   assign sto.tdata  = data2_reg;
   assign sto.tkeep  = keep2_reg;
   assign sto.tlast  = last2_reg;

   // Only kept lanes contribute to the status.
   assign hit = ovf_next & keep1_reg;

   generate
      for (genvar gi = 0; gi < DN; gi++) begin : g_lane
         logic [DWI-1:0] x;
         logic [PW-1:0]  xe;
         logic [PW-1:0]  me;
         logic [PW:0]    pr;
         logic [RW:0]    r;
         logic [SW-1:0]  s;
         logic [SW-DWO:0] top;
         logic           lane_unused;

         // Stage 1: full-width signed product.
         assign x  = sti.tdata[gi*DWI +: DWI];
         assign xe = {{DWM{x[DWI-1]}}, x};
         assign me = {{DWI{cfg_mul[DWM-1]}}, cfg_mul};
         assign p_next[gi] = $signed(xe) * $signed(me);

         // Stage 2: one extra bit keeps the rounding add from wrapping;
         // taking the upper slice is the arithmetic shift.
         assign pr = {p1_reg[gi][PW-1], p1_reg[gi]} + RND;
         assign r  = pr[PW:SHIFT];
         assign lane_unused = ^pr[SHIFT-1:0];

         assign s = {{(SW-RW-1){r[RW]}}, r} + {{(SW-DWO){cfg_off[DWO-1]}}, cfg_off};

         // In range exactly when every bit from the output sign bit up is
         // equal to the sum's sign.
         assign top = s[SW-1:DWO-1];
         assign ovf_next[gi] = ~((&top) | ~(|top));

         assign data_next[gi*DWO +: DWO] = (ovf_next[gi] & cfg_sat)
            ? (s[SW-1] ? {1'b1, {(DWO-1){1'b0}}} : {1'b0, {(DWO-1){1'b1}}})
            : s[DWO-1:0];
      end
   endgenerate

   // Control and status: reset clears the pipe so a partial packet is
   // dropped without ever presenting its tlast.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         v1_reg  <= 1'b0;
         v2_reg  <= 1'b0;
         sts_ovf <= '0;
         sts_cnt <= '0;
      end else begin
         if (rdy1) v1_reg <= sti.tvalid;
         if (rdy2) v2_reg <= v1_reg;

         // A clear in the same cycle as an overflow load restarts the
         // status from that event rather than losing it.
         if (ctl_clr) begin
            sts_ovf <= load2 ? hit : '0;
            sts_cnt <= (load2 && (|hit)) ? 32'd1 : 32'd0;
         end else if (load2 && (|hit)) begin
            sts_ovf <= sts_ovf | hit;
            if (sts_cnt != '1) sts_cnt <= sts_cnt + 32'd1;
         end
      end
   end

   // Datapath registers carry no reset; their contents only matter while
   // the matching valid bit is set.
   always_ff @(posedge ACLK) begin
      if (load1) begin
         p1_reg    <= p_next;
         keep1_reg <= sti.tkeep;
         last1_reg <= sti.tlast;
      end
      if (load2) begin
         data2_reg <= data_next;
         keep2_reg <= keep1_reg;
         last2_reg <= last1_reg;
      end
   end

endmodule

// File: tb/tb_lin_gain_sat.sv
// ---------------------------------------------------------------------------
// tb_lin_gain_sat
//   Two instances (ROUND=1 and ROUND=0) see identical stimulus; a reference
//   model pushes expected beats into one queue per instance when a beat is
//   accepted, and per-instance monitors pop and compare on output transfers.
// ---------------------------------------------------------------------------
module tb_lin_gain_sat;
   localparam int DN = 2;
   localparam int DW = 14;

   typedef struct {
      logic [DN*DW-1:0] data;
      logic [DN-1:0]    keep;
      logic             last;
   } exp_t;

   logic        clk = 1'b0;
   logic        ARESETn;
   logic [15:0] cfg_mul;
   logic [13:0] cfg_off;
   logic        cfg_sat;
   logic        ctl_clr;
   logic [1:0]  sts_ovf_a, sts_ovf_b;
   logic [31:0] sts_cnt_a, sts_cnt_b;

   int mul_i, off_i;
   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int bp_mode = 0;
   int hold_until = 0;
   logic [1:0]  exp_ovf;
   int          exp_cnt;
   exp_t q_a[$];
   exp_t q_b[$];

   assign cfg_mul = mul_i[15:0];
   assign cfg_off = off_i[13:0];

   lin_gain_sat_if #(.DN(DN), .DW(DW)) sti_a ();
   lin_gain_sat_if #(.DN(DN), .DW(DW)) sto_a ();
   lin_gain_sat_if #(.DN(DN), .DW(DW)) sti_b ();
   lin_gain_sat_if #(.DN(DN), .DW(DW)) sto_b ();

   assign sti_b.tdata  = sti_a.tdata;
   assign sti_b.tkeep  = sti_a.tkeep;
   assign sti_b.tlast  = sti_a.tlast;
   assign sti_b.tvalid = sti_a.tvalid;
   assign sto_b.tready = sto_a.tready;

   lin_gain_sat #(.DN(DN), .DWI(14), .DWM(16), .DWO(14), .SHIFT(14), .ROUND(1)) dut_a (
      .ACLK(clk), .ARESETn(ARESETn), .sti(sti_a.slave), .sto(sto_a.master),
      .cfg_mul(cfg_mul), .cfg_off(cfg_off), .cfg_sat(cfg_sat), .ctl_clr(ctl_clr),
      .sts_ovf(sts_ovf_a), .sts_cnt(sts_cnt_a));

   lin_gain_sat #(.DN(DN), .DWI(14), .DWM(16), .DWO(14), .SHIFT(14), .ROUND(0)) dut_b (
      .ACLK(clk), .ARESETn(ARESETn), .sti(sti_b.slave), .sto(sto_b.master),
      .cfg_mul(cfg_mul), .cfg_off(cfg_off), .cfg_sat(cfg_sat), .ctl_clr(ctl_clr),
      .sts_ovf(sts_ovf_b), .sts_cnt(sts_cnt_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference: {ovf, out[13:0]} for one lane.
   function automatic logic [14:0] model(int x, int mul, int off, bit sat, bit rnd);
      longint p, s;
      logic ovf;
      logic [13:0] o;
      p = longint'(x) * longint'(mul);
      if (rnd) p = p + 64'sd8192;
      p = p >>> 14;
      s = p + longint'(off);
      ovf = (s > 8191) || (s < -8192);
      if (ovf && sat) o = (s < 0) ? 14'h2000 : 14'h1fff;
      else            o = s[13:0];
      return {ovf, o};
   endfunction

   function automatic void push_beat(int x0, int x1, logic [1:0] keep, logic last, bit upd);
      exp_t e;
      logic [14:0] m0, m1;
      logic [1:0]  h;
      m0 = model(x0, mul_i, off_i, cfg_sat, 1'b1);
      m1 = model(x1, mul_i, off_i, cfg_sat, 1'b1);
      e.data = {m1[13:0], m0[13:0]};
      e.keep = keep;
      e.last = last;
      q_a.push_back(e);
      if (upd) begin
         h = {m1[14], m0[14]} & keep;
         exp_ovf = exp_ovf | h;
         if (|h) exp_cnt++;
      end
      m0 = model(x0, mul_i, off_i, cfg_sat, 1'b0);
      m1 = model(x1, mul_i, off_i, cfg_sat, 1'b0);
      e.data = {m1[13:0], m0[13:0]};
      q_b.push_back(e);
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accepting edge with
   // tvalid still asserted so beats can follow back to back.
   task automatic send(input int x0, input int x1, input logic [1:0] keep,
                       input logic last, input bit upd);
      int n;
      sti_a.tdata  = {14'(x1), 14'(x0)};
      sti_a.tkeep  = keep;
      sti_a.tlast  = last;
      sti_a.tvalid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!sti_a.tready && n < 500);
      if (!sti_a.tready) check("sti_accept", {63'd0, sti_a.tready}, 64'd1);
      push_beat(x0, x1, keep, last, upd);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      sti_a.tvalid = 1'b0;
      sti_a.tlast  = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q_a.size() != 0 || q_b.size() != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain", 64'(q_a.size() + q_b.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_sts(input string tag);
      check({tag, "_ovf"}, {62'd0, sts_ovf_a}, {62'd0, exp_ovf});
      check({tag, "_cnt"}, {32'd0, sts_cnt_a}, 64'(exp_cnt));
   endtask

   task automatic pulse_clr();
      ctl_clr = 1'b1;
      @(posedge clk);
      #1;
      ctl_clr = 1'b0;
      exp_ovf = '0;
      exp_cnt = 0;
   endtask

   // Sink readiness: 0 always ready, 1 random with optional hold, 2 stalled.
   initial begin
      sto_a.tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (bp_mode)
            0:       sto_a.tready = 1'b1;
            1:       sto_a.tready = (cyc < hold_until) ? 1'b0 : 1'($urandom_range(0, 1));
            default: sto_a.tready = 1'b0;
         endcase
      end
   end

   // Output monitors: compare on transfer, check stability under stall.
   logic        stall_a = 1'b0, stall_b = 1'b0;
   logic [30:0] held_a, held_b;

   always @(negedge clk) begin
      exp_t e;
      if (ARESETn === 1'b1 && sto_a.tvalid === 1'b1) begin
         if (stall_a) check("a_stable", {33'd0, sto_a.tdata, sto_a.tkeep, sto_a.tlast}, {33'd0, held_a});
         if (sto_a.tready === 1'b1) begin
            stall_a = 1'b0;
            if (q_a.size() == 0) check("a_queue_size", 64'(q_a.size()), 64'd1);
            else begin
               e = q_a.pop_front();
               $display("a beat: data=%07h keep=%b last=%b exp=%07h", sto_a.tdata, sto_a.tkeep, sto_a.tlast, e.data);
               check("a_data", 64'(sto_a.tdata), 64'(e.data));
               check("a_keep", 64'(sto_a.tkeep), 64'(e.keep));
               check("a_last", 64'(sto_a.tlast), 64'(e.last));
            end
         end else begin
            stall_a = 1'b1;
            held_a  = {sto_a.tdata, sto_a.tkeep, sto_a.tlast};
         end
      end else stall_a = 1'b0;
   end

   always @(negedge clk) begin
      exp_t e;
      if (ARESETn === 1'b1 && sto_b.tvalid === 1'b1) begin
         if (stall_b) check("b_stable", {33'd0, sto_b.tdata, sto_b.tkeep, sto_b.tlast}, {33'd0, held_b});
         if (sto_b.tready === 1'b1) begin
            stall_b = 1'b0;
            if (q_b.size() == 0) check("b_queue_size", 64'(q_b.size()), 64'd1);
            else begin
               e = q_b.pop_front();
               $display("b beat: data=%07h keep=%b last=%b exp=%07h", sto_b.tdata, sto_b.tkeep, sto_b.tlast, e.data);
               check("b_data", 64'(sto_b.tdata), 64'(e.data));
               check("b_keep", 64'(sto_b.tkeep), 64'(e.keep));
               check("b_last", 64'(sto_b.tlast), 64'(e.last));
            end
         end else begin
            stall_b = 1'b1;
            held_b  = {sto_b.tdata, sto_b.tkeep, sto_b.tlast};
         end
      end else stall_b = 1'b0;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ARESETn = 1'b0;
      ctl_clr = 1'b0;
      cfg_sat = 1'b1;
      mul_i   = 16384;
      off_i   = 0;
      exp_ovf = '0;
      exp_cnt = 0;
      sti_a.tdata  = '0;
      sti_a.tkeep  = '0;
      sti_a.tlast  = 1'b0;
      sti_a.tvalid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      ARESETn = 1'b1;
      check("rst_tvalid", {63'd0, sto_a.tvalid}, 64'd0);
      check("rst_tready", {63'd0, sti_a.tready}, 64'd1);
      check_sts("rst");
      @(posedge clk);
      #1;

      // Unity gain and two-cycle latency.
      send(1000, -1000, 2'b11, 1'b1, 1'b1);
      idle();
      @(negedge clk);
      check("lat_cycle1", {63'd0, sto_a.tvalid}, 64'd0);
      @(negedge clk);
      check("lat_cycle2", {63'd0, sto_a.tvalid}, 64'd1);
      drain();
      check_sts("unity");

      // Rounding: half gain on small values, both rounding modes.
      mul_i = 8192;
      send(1, -1, 2'b11, 1'b0, 1'b1);
      send(3, -3, 2'b11, 1'b1, 1'b1);
      idle();
      drain();
      check_sts("round");

      // Saturation, then wrap.
      mul_i = 32767;
      send(8191, -8192, 2'b11, 1'b1, 1'b1);
      idle();
      drain();
      check_sts("sat");
      cfg_sat = 1'b0;
      send(8191, -8192, 2'b11, 1'b1, 1'b1);
      idle();
      drain();
      check_sts("wrap");
      cfg_sat = 1'b1;
      pulse_clr();
      check_sts("clr");

      // Offset.
      mul_i = 16384;
      off_i = 500;
      send(8000, 0, 2'b11, 1'b0, 1'b1);
      idle();
      drain();
      off_i = -100;
      send(0, 0, 2'b11, 1'b1, 1'b1);
      idle();
      drain();
      check_sts("offset");

      // Overflow on a lane with tkeep=0 does not touch the status.
      off_i = 0;
      mul_i = 32767;
      send(0, 8191, 2'b01, 1'b1, 1'b1);
      idle();
      drain();
      check_sts("nokeep");
      send(0, 8191, 2'b11, 1'b1, 1'b1);
      idle();
      drain();
      check_sts("keep");

      // Clear in the same cycle as an overflowing stage-2 load.
      send(8191, 0, 2'b11, 1'b1, 1'b0);
      idle();
      ctl_clr = 1'b1;
      @(posedge clk);
      #1;
      ctl_clr = 1'b0;
      exp_ovf = 2'b01;
      exp_cnt = 1;
      drain();
      check_sts("clr_ovf");

      // Backpressured ramp.
      mul_i = 16384;
      bp_mode = 1;
      for (int i = 0; i < 20; i++) begin
         if (i == 8) hold_until = cyc + 5;
         send(i * 100 - 1000, -i * 50, 2'b11, (i == 19), 1'b1);
      end
      idle();
      drain();
      bp_mode = 0;
      check_sts("ramp");

      // Reset with a full, stalled pipe.
      bp_mode = 2;
      repeat (2) @(posedge clk);
      #1;
      mul_i = 32767;
      send(8191, 0, 2'b11, 1'b0, 1'b1);
      send(100, 100, 2'b11, 1'b0, 1'b1);
      idle();
      @(posedge clk);
      #3;
      check("pre_rst_cnt", {32'd0, sts_cnt_a}, 64'(exp_cnt));
      ARESETn = 1'b0;
      #1;
      q_a.delete();
      q_b.delete();
      exp_ovf = '0;
      exp_cnt = 0;
      check("midrst_tvalid", {63'd0, sto_a.tvalid}, 64'd0);
      check_sts("midrst");
      repeat (2) @(negedge clk);
      ARESETn = 1'b1;
      bp_mode = 0;
      repeat (3) @(negedge clk);
      check("post_rst_tvalid", {63'd0, sto_a.tvalid}, 64'd0);
      @(posedge clk);
      #1;
      mul_i = 16384;
      send(123, -456, 2'b10, 1'b1, 1'b1);
      idle();
      drain();
      check_sts("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
